bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the FND control unit and converts raw binary measurements (e.g. the 9-bit ultrasonic distance, 0..399 cm) into packed BCD digits for the display controllers.
- Uses a start/busy/done handshake.
- Holds its last result stable, so the display never sees intermediate values.

Parameters:
- WIDTH, 9: bit width of the binary input.
- DIGITS, 3: number of BCD output digits. MAXVAL = 10^DIGITS - 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-low. When rst = 0, all registers clear immediately.
- start  in  1  request a conversion. Sampled only in IDLE.
- bin  in  WIDTH  binary value. Captured on the edge that accepts start.
- busy  out  1  high from acceptance until the end of the DONE cycle.
- done  out  1  single-cycle pulse when bcd/ovf are updated.
- bcd  out  4*DIGITS  packed result, most-significant digit in the top nibble. Held until the next done.
- ovf  out  1  set with done when the captured bin > MAXVAL. Held with bcd.

Behaviour:
- Reset values: state = IDLE, busy = 0, done = 0, bcd = 0, ovf = 0, internal shift/count registers = 0.
- Reset mid-conversion aborts the conversion; no done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT when start = 1 at edge E0 (same edge):
  - load the binary shift register with bin;
  - clear the BCD scratch register;
  - cnt = WIDTH-1;
  - latch ovf_pend = (bin > MAXVAL).
- SHIFT, each edge:
  - every scratch digit ≥ 5 gets +3 (per-digit, combinational);
  - then {scratch, binreg} shifts left 1;
  - cnt decrements.
- On the SHIFT edge with cnt = 0 (edge E_WIDTH):
  - state → DONE, done ← 1;
  - if ovf_pend = 1: bcd ← all nibbles 4'h9, ovf ← 1;
  - else: bcd ← the post-shift scratch value, ovf ← 0.
- DONE → IDLE on the next edge; done ← 0.
- Timing:
  - done is high in the single cycle after edge E_WIDTH.
  - busy = (state ≠ IDLE), registered, high from E0 through the DONE cycle.
  - Minimum start-to-start period is WIDTH+2 cycles.
  - If start is held high continuously, a conversion begins every WIDTH+2 cycles.
- start while in SHIFT or DONE is ignored (not queued).
- bin changes after capture have no effect on the running conversion.
- Scratch width is 4*DIGITS. Bits shifted out of the top of scratch are discarded; overflow is reported only via ovf_pend/ovf.
- bin = 0 yields bcd = 0, ovf = 0 after the normal latency.
- bcd/ovf change only on the done edge or on reset.

Decomposition:
- Shared package fnd_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the digit-width constant 4;
  - a constant function pow10(DIGITS) used for MAXVAL.
- One sub-module, bcd_adj3: a 4-bit combinational "if ≥ 5 add 3" cell, instantiated DIGITS times in a generate loop.
- The rest is a single FSM with its datapath.

Test Plan:
- Reset/idle: rst = 0 then 1 → busy = 0, done = 0, bcd = 12'h000, ovf = 0; no done pulses while start = 0.
- Nominal conversion: start = 1 for one cycle at E0 with bin = 399 → busy goes high at E0, done pulses exactly once in the cycle after E9, bcd = 12'h399, ovf = 0, busy low after E10.
- Zero and edge values:
  - bin = 0 → bcd = 12'h000, ovf = 0;
  - bin = 100 → 12'h100;
  - bin = 9 → 12'h009.
- Overflow: bin = 511 (> 999 impossible at WIDTH = 9, so rerun with WIDTH = 10, bin = 1023) → bcd = 12'h999, ovf = 1. Also: with WIDTH = 10, bin = 999 → 12'h999, ovf = 0.
- Handshake robustness:
  - start re-pulsed at E3 and bin changed to 7 mid-conversion → result still 12'h399, single done;
  - start held high continuously → done pulses every 11 cycles.
- Async reset mid-op: drive rst low at E5 of a conversion → outputs clear immediately, no done; after release, a new start with bin = 42 → bcd = 12'h042.

Source files
------------

// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared types and constants for the FND display path
package fnd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // 10^n, evaluated at elaboration to size the overflow threshold
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_adj3.sv
// rtl/bcd_adj3.sv - per-digit "add 3 if >= 5" correction cell for double dabble
module bcd_adj3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // pre-correct so the following left shift carries into the next decade
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential binary-to-packed-BCD converter, one bit per clock
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WIDTH-1:0]            bin,
  output logic                        busy,
  output logic                        done,
  output logic [DIGIT_W*DIGITS-1:0]   bcd,
  output logic                        ovf
);

  localparam int          SW     = DIGIT_W * DIGITS;
  localparam int          CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [31:0] MAXVAL = 32'(pow10(DIGITS) - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] binreg;
  logic [SW-1:0]    scratch;
  logic [SW-1:0]    scratch_adj;
  logic [SW-1:0]    scratch_shl;
  logic             ovf_pend;
  logic             last_shift;
  logic             shift_out_unused;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .din  (scratch[g*DIGIT_W +: DIGIT_W]),
      .dout (scratch_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // corrected scratch shifted left with the next binary bit entering at the bottom;
  // the bit leaving the top is dropped, overflow is tracked separately by ovf_pend
  assign scratch_shl      = {scratch_adj[SW-2:0], binreg[WIDTH-1]};
  assign shift_out_unused = scratch_adj[SW-1];
  assign last_shift       = (state == SHIFT) && (cnt == '0);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state: start only honoured in IDLE, one edge spent in DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: capture on accept, shift-add-3 while shifting, publish on the last shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
      cnt      <= '0;
      binreg   <= '0;
      scratch  <= '0;
      ovf_pend <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= last_shift;
      case (state)
        IDLE: begin
          if (start) begin
            binreg   <= bin;
            scratch  <= '0;
            cnt      <= CW'(WIDTH - 1);
            ovf_pend <= (32'(bin) > MAXVAL);
          end
        end
        SHIFT: begin
          scratch <= scratch_shl;
          binreg  <= {binreg[WIDTH-2:0], 1'b0};
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
          if (last_shift) begin
            if (ovf_pend) begin
              bcd <= {DIGITS{4'h9}};
              ovf <= 1'b1;
            end else begin
              bcd <= scratch_shl;
              ovf <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - randomized self-checking bench for bin2bcd_seq (WIDTH 9 and 10)
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  bin9 = '0;
  logic [9:0]  bin10 = '0;
  logic        busy9, done9, ovf9, busy10, done10, ovf10;
  logic [11:0] bcd9, bcd10;

  int vec = 0;
  int err = 0;
  int ndone9 = 0;
  int ndone10 = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(9), .DIGITS(3)) dut9 (
    .clk(clk), .rst(rst), .start(start), .bin(bin9),
    .busy(busy9), .done(done9), .bcd(bcd9), .ovf(ovf9)
  );

  bin2bcd_seq #(.WIDTH(10), .DIGITS(3)) dut10 (
    .clk(clk), .rst(rst), .start(start), .bin(bin10),
    .busy(busy10), .done(done10), .bcd(bcd10), .ovf(ovf10)
  );

  always @(negedge clk) begin
    if (done9 === 1'b1) ndone9++;
    if (done10 === 1'b1) ndone10++;
  end

  function automatic logic [11:0] exp_bcd(input int v);
    if (v > 999) return 12'h999;
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic exp_ovf(input int v);
    return v > 999;
  endfunction

  task automatic conv(input int v9, input int v10, input bit repulse);
    int n9, n10, d9_at, d10_at;
    @(negedge clk);
    bin9 = 9'(v9); bin10 = 10'(v10); start = 1'b1;
    n9 = ndone9; n10 = ndone10; d9_at = -1; d10_at = -1;
    @(posedge clk); #1;
    start = 1'b0;
    vec++;
    if (busy9 !== 1'b1 || busy10 !== 1'b1) begin
      err++; $display("FAIL busy_at_e0: got %b/%b want 1/1", busy9, busy10);
    end
    for (int i = 1; i <= 13; i++) begin
      @(posedge clk); #1;
      if (repulse && i == 2) begin start = 1'b1; bin9 = 9'd7; bin10 = 10'd7; end
      if (repulse && i == 3) start = 1'b0;
      if (done9 === 1'b1 && d9_at < 0) d9_at = i;
      if (done10 === 1'b1 && d10_at < 0) d10_at = i;
      if (i == 9 || i == 10) begin
        vec++;
        if (busy9 !== (i == 9)) begin
          err++; $display("FAIL busy9_edge%0d: got %b want %b", i, busy9, i == 9);
        end
      end
      if (i == 11) begin
        vec++;
        if (busy10 !== 1'b0) begin
          err++; $display("FAIL busy10_after_done: got %b want 0", busy10);
        end
      end
    end
    vec++;
    if (d9_at != 9 || d10_at != 10) begin
      err++; $display("FAIL done_latency: got %0d/%0d want 9/10", d9_at, d10_at);
    end
    vec++;
    if (ndone9 - n9 != 1 || ndone10 - n10 != 1) begin
      err++; $display("FAIL done_count: got %0d/%0d want 1/1", ndone9 - n9, ndone10 - n10);
    end
    vec++;
    if (bcd9 !== exp_bcd(v9) || ovf9 !== exp_ovf(v9)) begin
      err++; $display("FAIL result9 bin=%0d: got %h ovf=%b want %h ovf=%b",
                      v9, bcd9, ovf9, exp_bcd(v9), exp_ovf(v9));
    end
    vec++;
    if (bcd10 !== exp_bcd(v10) || ovf10 !== exp_ovf(v10)) begin
      err++; $display("FAIL result10 bin=%0d: got %h ovf=%b want %h ovf=%b",
                      v10, bcd10, ovf10, exp_bcd(v10), exp_ovf(v10));
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    vec++;
    if ({busy9, done9, ovf9, busy10, done10, ovf10} !== 6'b0 || bcd9 !== 12'h000 || bcd10 !== 12'h000) begin
      err++; $display("FAIL reset_values: got b%b d%b o%b bcd=%h / b%b d%b o%b bcd=%h want all 0",
                      busy9, done9, ovf9, bcd9, busy10, done10, ovf10, bcd10);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    vec++;
    if (ndone9 != 0 || ndone10 != 0 || busy9 !== 1'b0 || busy10 !== 1'b0) begin
      err++; $display("FAIL idle_quiet: got done %0d/%0d busy %b/%b want 0", ndone9, ndone10, busy9, busy10);
    end
  endtask

  task automatic test_nominal;
    conv(399, 399, 1'b0);
  endtask

  task automatic test_edge_values;
    conv(0, 0, 1'b0);
    conv(100, 999, 1'b0);
    conv(9, 1023, 1'b0);
    conv(511, 1000, 1'b0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 8; k++) begin
      conv(int'($urandom_range(0, 511)), int'($urandom_range(0, 1023)), 1'b0);
    end
  endtask

  task automatic test_restart_ignored;
    conv(399, 399, 1'b1);
  endtask

  task automatic test_back_to_back;
    int t9[$];
    int t10[$];
    int v9, v10;
    v9 = int'($urandom_range(0, 511));
    v10 = int'($urandom_range(0, 1023));
    @(negedge clk);
    bin9 = 9'(v9); bin10 = 10'(v10); start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (done9 === 1'b1) t9.push_back(c);
      if (done10 === 1'b1) t10.push_back(c);
    end
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    vec++;
    if (t9.size() < 5 || t10.size() < 4) begin
      err++; $display("FAIL b2b_count: got %0d/%0d want >=5/>=4", t9.size(), t10.size());
    end
    for (int j = 1; j < t9.size(); j++) begin
      vec++;
      if (t9[j] - t9[j-1] != 11) begin
        err++; $display("FAIL b2b_period9: got %0d want 11", t9[j] - t9[j-1]);
      end
    end
    for (int j = 1; j < t10.size(); j++) begin
      vec++;
      if (t10[j] - t10[j-1] != 12) begin
        err++; $display("FAIL b2b_period10: got %0d want 12", t10[j] - t10[j-1]);
      end
    end
    vec++;
    if (bcd9 !== exp_bcd(v9) || bcd10 !== exp_bcd(v10) || ovf10 !== exp_ovf(v10)) begin
      err++; $display("FAIL b2b_result: got %h/%h ovf=%b want %h/%h ovf=%b",
                      bcd9, bcd10, ovf10, exp_bcd(v9), exp_bcd(v10), exp_ovf(v10));
    end
  endtask

  task automatic test_async_reset;
    int n9, n10;
    conv(287, 1023, 1'b0);
    @(negedge clk);
    bin9 = 9'd321; bin10 = 10'd654; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    vec++;
    if ({busy9, done9, ovf9, busy10, done10, ovf10} !== 6'b0 || bcd9 !== 12'h000 || bcd10 !== 12'h000) begin
      err++; $display("FAIL async_clear: got bcd=%h/%h ovf=%b/%b busy=%b/%b want 0",
                      bcd9, bcd10, ovf9, ovf10, busy9, busy10);
    end
    n9 = ndone9; n10 = ndone10;
    repeat (15) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (ndone9 != n9 || ndone10 != n10) begin
      err++; $display("FAIL abort_no_done: got %0d/%0d extra dones want 0", ndone9 - n9, ndone10 - n10);
    end
    conv(42, 42, 1'b0);
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_edge_values;
    test_random;
    test_restart_ignored;
    test_back_to_back;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
